scope_trace_renderer: RTL

Upstream stage of the VGA pixel driver in the oscilloscope datapath. Captures 8-bit ADC samples after a rising-edge trigger (with auto-trigger timeout) into a ping-pong pair of 640-entry buffers. For every pixel the VGA scan reports, it returns the RGB colour: waveform trace, graticule or black. The driver consumes that colour directly.

---
 rtl/scope_trace_renderer_pkg.sv | 32 +++
 rtl/scope_trace_renderer_if.sv | 27 ++
 rtl/scope_trace_renderer_ram.sv | 28 ++
 rtl/scope_trace_renderer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/scope_trace_renderer_pkg.sv
// Shared types and constants for the scope trace renderer.
package scope_trace_renderer_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int SAMPLE_W    = 8;
  localparam int ADDR_W      = 10;
  localparam int COORD_W     = 10;
  localparam int GRID_MASK_W = 6;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } cap_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t TRACE = '{r: 8'd0,  g: 8'd255, b: 8'd0};
  localparam rgb_t GRID  = '{r: 8'd64, g: 8'd64,  b: 8'd64};
  localparam rgb_t BLACK = '{r: 8'd0,  g: 8'd0,   b: 8'd0};

  // Screen row of a sample: full scale sits at y_off, zero at y_off + 255.
  function automatic logic [COORD_W-1:0] trace_row(input logic [SAMPLE_W-1:0] s,
                                                   input logic [COORD_W-1:0] y_off);
    return y_off + COORD_W'(8'd255 - s);
  endfunction

endpackage

// File: rtl/scope_trace_renderer_if.sv
// Sample, scan and colour signals between the scope front end and the VGA driver.
interface scope_trace_renderer_if;
  import scope_trace_renderer_pkg::*;

  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] trig_level;
  logic [COORD_W-1:0]  scan_x;
  logic [COORD_W-1:0]  scan_y;
  logic                scan_valid;
  logic                frame_start;
  logic [7:0]          colour_R;
  logic [7:0]          colour_G;
  logic [7:0]          colour_B;
  logic                armed;
  logic                triggered;

  modport master (
    output sample_in, sample_valid, trig_level, scan_x, scan_y, scan_valid, frame_start,
    input  colour_R, colour_G, colour_B, armed, triggered
  );

  modport slave (
    input  sample_in, sample_valid, trig_level, scan_x, scan_y, scan_valid, frame_start,
    output colour_R, colour_G, colour_B, armed, triggered
  );
endinterface

// File: rtl/scope_trace_renderer_ram.sv
// Ping-pong sample store: two banks of H_ACTIVE samples, one write port, one registered read port.
module scope_sample_ram
  import scope_trace_renderer_pkg::*;
(
  input  logic                clock,
  input  logic                wr_en,
  input  logic                wr_bank,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic                rd_en,
  input  logic                rd_bank,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [SAMPLE_W-1:0] rd_data
);

  logic [SAMPLE_W-1:0] mem [2][H_ACTIVE];

  // capture writes into the back bank
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
  end

  // registered read for the pixel pipeline
  always_ff @(posedge clock) begin
    if (rd_en) rd_data <= mem[rd_bank][rd_addr];
  end

endmodule

// File: rtl/scope_trace_renderer.sv
// Trigger/capture control and two-stage pixel colour pipeline for the scope display.
//
//   state   | meaning
//   ARMED   | waiting for rising crossing of trig_level or auto timeout
//   CAPTURE | writing consecutive samples into the back bank
//   DONE    | back bank full, waiting for frame_start to swap banks
module scope_trace_renderer
  import scope_trace_renderer_pkg::*;
#(
  parameter int Y_OFFSET     = 112,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic                   clock,
  input  logic                   reset,
  scope_trace_renderer_if.slave  bus
);

  localparam logic [15:0]        AUTO_LIM  = 16'(AUTO_TIMEOUT);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_OFF     = COORD_W'(Y_OFFSET);

  cap_state_t          state, state_nx;
  logic [ADDR_W-1:0]   wr_addr, wr_addr_nx;
  logic [15:0]         auto_cnt, auto_cnt_nx;
  logic [SAMPLE_W-1:0] prev_sample;
  logic                disp_bank, shown, swap, trig_fire, wr_en, triggered_q;

  logic                rd_en, s1_valid;
  logic [COORD_W-1:0]  s1_x, s1_y, t_cur, t_left, t_lo, t_hi;
  logic [SAMPLE_W-1:0] rd_data, prev_col, left_s;
  logic                lit, on_grid;
  rgb_t                colour_q, colour_nx;

  // capture state register, bank/shown flags and trigger history
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ARMED;
      wr_addr     <= '0;
      auto_cnt    <= '0;
      prev_sample <= '0;
      disp_bank   <= 1'b0;
      shown       <= 1'b0;
      triggered_q <= 1'b0;
    end else begin
      state       <= state_nx;
      wr_addr     <= wr_addr_nx;
      auto_cnt    <= auto_cnt_nx;
      triggered_q <= trig_fire;
      if (bus.sample_valid) prev_sample <= bus.sample_in;
      if (swap) begin
        disp_bank <= ~disp_bank;
        shown     <= 1'b1;
      end
    end
  end

  // next state, write strobe and trigger detection; wr_addr rests at 0 outside CAPTURE
  always_comb begin
    state_nx    = state;
    wr_addr_nx  = wr_addr;
    auto_cnt_nx = auto_cnt;
    wr_en       = 1'b0;
    trig_fire   = 1'b0;
    swap        = 1'b0;
    case (state)
      ARMED: begin
        if (bus.sample_valid) begin
          auto_cnt_nx = auto_cnt + 16'd1;
          if ((prev_sample < bus.trig_level && bus.sample_in >= bus.trig_level) ||
              (AUTO_LIM != 16'd0 && auto_cnt_nx == AUTO_LIM)) begin
            trig_fire   = 1'b1;
            wr_en       = 1'b1;
            state_nx    = CAPTURE;
            wr_addr_nx  = ADDR_W'(1);
            auto_cnt_nx = '0;
          end
        end
      end
      CAPTURE: begin
        if (bus.sample_valid) begin
          wr_en = 1'b1;
          if (wr_addr == LAST_ADDR) begin
            state_nx   = DONE;
            wr_addr_nx = '0;
          end else begin
            wr_addr_nx = wr_addr + ADDR_W'(1);
          end
        end
      end
      DONE: begin
        if (bus.frame_start) begin
          swap     = 1'b1;
          state_nx = ARMED;
        end
      end
      default: state_nx = ARMED;
    endcase
  end

  assign bus.armed     = (state == ARMED);
  assign bus.triggered = triggered_q;
  assign rd_en         = bus.scan_valid && (bus.scan_x < COORD_W'(H_ACTIVE));

  scope_sample_ram u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_bank (~disp_bank),
    .wr_addr (wr_addr),
    .wr_data (bus.sample_in),
    .rd_en   (rd_en),
    .rd_bank (disp_bank),
    .rd_addr (bus.scan_x),
    .rd_data (rd_data)
  );

  // stage 1: carry scan coordinates alongside the RAM read; remember last column's sample
  always_ff @(posedge clock) begin
    if (reset) s1_valid <= 1'b0;
    else       s1_valid <= rd_en;
    s1_x <= bus.scan_x;
    s1_y <= bus.scan_y;
    if (s1_valid) prev_col <= rd_data;
  end

  // vertical line fill between neighbouring samples, then colour priority
  always_comb begin
    left_s    = (s1_x == '0) ? rd_data : prev_col;
    t_cur     = trace_row(rd_data, Y_OFF);
    t_left    = trace_row(left_s, Y_OFF);
    t_lo      = (t_cur < t_left) ? t_cur : t_left;
    t_hi      = (t_cur < t_left) ? t_left : t_cur;
    lit       = (s1_y >= t_lo) && (s1_y <= t_hi);
    on_grid   = (s1_x[GRID_MASK_W-1:0] == '0) || (s1_y[GRID_MASK_W-1:0] == '0);
    colour_nx = BLACK;
    if (s1_valid) begin
      if (lit && shown)  colour_nx = TRACE;
      else if (on_grid)  colour_nx = GRID;
    end
  end

  // stage 2: registered colour output
  always_ff @(posedge clock) begin
    if (reset) colour_q <= BLACK;
    else       colour_q <= colour_nx;
  end

  assign bus.colour_R = colour_q.r;
  assign bus.colour_G = colour_q.g;
  assign bus.colour_B = colour_q.b;

endmodule
